// File: rtl/l2_req_arbiter.sv
// rtl/l2_req_arbiter.sv - arbitrates the shared L2 port between icache and dcache miss paths
//
// Purpose: grants the single L2 request port to one of the icache or dcache
// controllers. It captures the winner's addr/rw/wd, issues l2_req, returns
// rdy and refill data to the owner only, and holds the grant until the
// owner signals complete.
//
// Configuration macro: ARB_RR_EN
//   defined   - round-robin on simultaneous requests (DC wins the first tie)
//   undefined - fixed priority, dcache wins every tie
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ic_irq/addr/rw/complete     icache request side
//   ic_busy, ic_rdy             L2 unavailable / data valid for icache
//   dc_irq/addr/rw/wd/complete  dcache request side
//   dc_busy, dc_rdy             L2 unavailable / op done for dcache
//   l2_req/addr/rw/wd           captured request towards L2
//   l2_ack, l2_rd               L2 completion and read block
//   rd_data                     l2_rd passthrough, valid while a rdy is high
module l2_req_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_irq,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_rw,
  input  logic              ic_complete,
  output logic              ic_busy,
  output logic              ic_rdy,
  input  logic              dc_irq,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_rw,
  input  logic [DATA_W-1:0] dc_wd,
  input  logic              dc_complete,
  output logic              dc_busy,
  output logic              dc_rdy,
  output logic              l2_req,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_rw,
  output logic [DATA_W-1:0] l2_wd,
  input  logic              l2_ack,
  input  logic [DATA_W-1:0] l2_rd,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_CMP, RELEASE} state_t;

  localparam logic SIDE_IC = 1'b0;
  localparam logic SIDE_DC = 1'b1;

  state_t state;
  logic   owner;
  logic   winner;
  logic   ack_hit;
  logic   owner_complete;

`ifdef ARB_RR_EN
  // Side served most recently; a tie goes to the other side.
  logic rr_ptr;

  always_comb begin
    winner = SIDE_IC;
    if (dc_irq && (!ic_irq || rr_ptr == SIDE_IC)) winner = SIDE_DC;
  end
`else
  always_comb begin
    winner = dc_irq ? SIDE_DC : SIDE_IC;
  end
`endif

  assign owner_complete = (owner == SIDE_DC) ? dc_complete : ic_complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= SIDE_IC;
      l2_req  <= 1'b0;
      l2_addr <= '0;
      l2_rw   <= 1'b0;
      l2_wd   <= '0;
`ifdef ARB_RR_EN
      rr_ptr  <= SIDE_IC;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ic_irq || dc_irq) begin
            owner   <= winner;
            l2_addr <= (winner == SIDE_DC) ? dc_addr : ic_addr;
            l2_rw   <= (winner == SIDE_DC) ? dc_rw : ic_rw;
            l2_wd   <= (winner == SIDE_DC) ? dc_wd : '0;
            l2_req  <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          // Held until ack even if the owner drops irq: no abort path.
          if (l2_ack) begin
            l2_req <= 1'b0;
            state  <= WAIT_CMP;
          end
        end
        WAIT_CMP: begin
          if (owner_complete) state <= RELEASE;
        end
        RELEASE: begin
`ifdef ARB_RR_EN
          rr_ptr <= owner;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ack_hit = (state == REQ) && l2_ack;
  assign ic_rdy  = ack_hit && (owner == SIDE_IC);
  assign dc_rdy  = ack_hit && (owner == SIDE_DC);
  assign rd_data = ack_hit ? l2_rd : '0;

  // In IDLE the registered owner is stale, so only a same-cycle tie
  // produces busy (for the side that loses it).
  always_comb begin
    ic_busy = 1'b0;
    dc_busy = 1'b0;
    if (state == IDLE) begin
      if (ic_irq && dc_irq) begin
        ic_busy = (winner == SIDE_DC);
        dc_busy = (winner == SIDE_IC);
      end
    end else begin
      ic_busy = (owner == SIDE_DC);
      dc_busy = (owner == SIDE_IC);
    end
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb/tb_l2_req_arbiter.sv - randomized scoreboard testbench for l2_req_arbiter
module tb_l2_req_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam logic IC = 1'b0;
  localparam logic DC = 1'b1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ic_irq = 1'b0;
  logic [ADDR_W-1:0] ic_addr = '0;
  logic              ic_rw = 1'b0;
  logic              ic_complete = 1'b0;
  logic              ic_busy, ic_rdy;
  logic              dc_irq = 1'b0;
  logic [ADDR_W-1:0] dc_addr = '0;
  logic              dc_rw = 1'b0;
  logic [DATA_W-1:0] dc_wd = '0;
  logic              dc_complete = 1'b0;
  logic              dc_busy, dc_rdy;
  logic              l2_req;
  logic [ADDR_W-1:0] l2_addr;
  logic              l2_rw;
  logic [DATA_W-1:0] l2_wd;
  logic              l2_ack = 1'b0;
  logic [DATA_W-1:0] l2_rd = '0;
  logic [DATA_W-1:0] rd_data;

  l2_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .ic_irq(ic_irq), .ic_addr(ic_addr), .ic_rw(ic_rw), .ic_complete(ic_complete),
    .ic_busy(ic_busy), .ic_rdy(ic_rdy),
    .dc_irq(dc_irq), .dc_addr(dc_addr), .dc_rw(dc_rw), .dc_wd(dc_wd),
    .dc_complete(dc_complete), .dc_busy(dc_busy), .dc_rdy(dc_rdy),
    .l2_req(l2_req), .l2_addr(l2_addr), .l2_rw(l2_rw), .l2_wd(l2_wd),
    .l2_ack(l2_ack), .l2_rd(l2_rd), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              side;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

`ifdef ARB_RR_EN
  logic last_served = IC;
`endif

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: who wins when both sides ask at once.
  function automatic logic tie_winner();
`ifdef ARB_RR_EN
    return (last_served == IC) ? DC : IC;
`else
    return DC;
`endif
  endfunction

  task automatic note_served(input logic side);
`ifdef ARB_RR_EN
    last_served = side;
`else
    if (side !== IC && side !== DC) $display("note: bad side");
`endif
  endtask

  task automatic model_reset();
`ifdef ARB_RR_EN
    last_served = IC;
`endif
  endtask

  function automatic logic [DATA_W-1:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push_exp(input logic side, input logic [DATA_W-1:0] rd);
    exp_t e;
    e.side = side;
    e.addr = side ? dc_addr : ic_addr;
    e.rw   = side ? dc_rw : ic_rw;
    e.wd   = side ? dc_wd : '0;
    e.rd   = rd;
    sbq.push_back(e);
    note_served(side);
  endtask

  // Monitor: every rdy pulse is matched against the next expected grant.
  initial begin
    forever begin
      @(negedge clk);
      if (ic_rdy || dc_rdy) begin
        exp_t e;
        if (sbq.size() == 0) begin
          chk("unexpected_rdy", 1'b1, 1'b0);
        end else begin
          e = sbq.pop_front();
          chk("rdy_side", dc_rdy, e.side);
          chk("rdy_both", ic_rdy & dc_rdy, 1'b0);
          chk("l2_addr", l2_addr, e.addr);
          chk("l2_rw", l2_rw, e.rw);
          chk("l2_wd", l2_wd, e.wd);
          chk("rd_data", rd_data, e.rd);
        end
      end
    end
  end

  // Drives one grant from its IDLE cycle through RELEASE; DUT is in IDLE on entry.
  task automatic serve(input logic side, input logic [DATA_W-1:0] rd, input bit raise_other);
    int d;
    int w;
    @(negedge clk);
    if (ic_irq && dc_irq) begin
      chk("idle_loser_busy", side ? ic_busy : dc_busy, 1'b1);
      chk("idle_winner_busy", side ? dc_busy : ic_busy, 1'b0);
    end else begin
      chk("idle_busy", ic_busy | dc_busy, 1'b0);
    end
    chk("idle_req", l2_req, 1'b0);
    step();
    if (side) dc_irq = 1'b0; else ic_irq = 1'b0;
    d = $urandom_range(0, 3);
    repeat (d) begin
      @(negedge clk);
      chk("req_high", l2_req, 1'b1);
      chk("req_owner_busy", side ? dc_busy : ic_busy, 1'b0);
      chk("req_other_busy", side ? ic_busy : dc_busy, 1'b1);
      chk("req_no_rdy", ic_rdy | dc_rdy, 1'b0);
      step();
    end
    l2_ack = 1'b1;
    l2_rd  = rd;
    @(negedge clk);
    chk("ack_req_high", l2_req, 1'b1);
    step();
    l2_ack = 1'b0;
    l2_rd  = rand_blk();
    if (raise_other) begin
      if (side) ic_irq = 1'b1; else dc_irq = 1'b1;
    end
    w = $urandom_range(0, 2);
    repeat (w) begin
      if (side) ic_complete = $urandom_range(0, 1); else dc_complete = $urandom_range(0, 1);
      @(negedge clk);
      chk("wait_req_low", l2_req, 1'b0);
      chk("wait_other_busy", side ? ic_busy : dc_busy, 1'b1);
      chk("wait_no_rdy", ic_rdy | dc_rdy, 1'b0);
      step();
    end
    ic_complete = (side == IC);
    dc_complete = (side == DC);
    @(negedge clk);
    chk("cmp_other_busy", side ? ic_busy : dc_busy, 1'b1);
    step();
    ic_complete = 1'b0;
    dc_complete = 1'b0;
    @(negedge clk);
    chk("rel_req_low", l2_req, 1'b0);
    chk("rel_owner_busy", side ? dc_busy : ic_busy, 1'b0);
    chk("rel_other_busy", side ? ic_busy : dc_busy, 1'b1);
    step();
  endtask

  // pat: 0 IC only, 1 DC only, 2 tie, 3 one side then the other raised during WAIT_CMP
  task automatic round(input int pat, input logic late_first);
    logic w;
    logic [DATA_W-1:0] rd_w, rd_l;
    rd_w = rand_blk();
    rd_l = rand_blk();
    case (pat)
      0: w = IC;
      1: w = DC;
      2: w = tie_winner();
      default: w = late_first;
    endcase
    push_exp(w, rd_w);
    if (pat >= 2) push_exp(~w, rd_l);
    if (pat == 2) begin
      ic_irq = 1'b1;
      dc_irq = 1'b1;
    end else begin
      ic_irq = (w == IC);
      dc_irq = (w == DC);
    end
    serve(w, rd_w, pat == 3);
    if (pat >= 2) serve(~w, rd_l, 1'b0);
  endtask

  task automatic rand_inputs();
    ic_addr = ADDR_W'($urandom);
    ic_rw   = $urandom_range(0, 1);
    dc_addr = ADDR_W'($urandom);
    dc_rw   = $urandom_range(0, 1);
    dc_wd   = rand_blk();
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_l2_req"}, l2_req, 1'b0);
    chk({tag, "_l2_addr"}, l2_addr, '0);
    chk({tag, "_l2_rw"}, l2_rw, 1'b0);
    chk({tag, "_l2_wd"}, l2_wd, '0);
    chk({tag, "_busy"}, {ic_busy, dc_busy}, 2'b00);
    chk({tag, "_rdy"}, {ic_rdy, dc_rdy}, 2'b00);
    chk({tag, "_rd_data"}, rd_data, '0);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    rst = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    step();
    rst = 1'b0;

    // IC-only read of a fixed block
    ic_addr = 28'h0000123;
    ic_rw   = 1'b0;
    round(0, IC);

    // DC writeback of an all-A5 block
    dc_addr = 28'h0ABCDEF;
    dc_rw   = 1'b1;
    dc_wd   = {16{8'hA5}};
    round(1, DC);

    // Two ties in a row, then IC arriving while DC waits for complete
    rand_inputs();
    round(2, IC);
    rand_inputs();
    round(2, IC);
    rand_inputs();
    round(3, DC);

    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      round($urandom_range(0, 3), $urandom_range(0, 1));
    end

    // Reset while in WAIT_CMP abandons the grant
    rand_inputs();
    rd = rand_blk();
    push_exp(DC, rd);
    dc_irq = 1'b1;
    step();
    dc_irq = 1'b0;
    l2_ack = 1'b1;
    l2_rd  = rd;
    step();
    l2_ack = 1'b0;
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
    check_reset_outputs("midrst");
    step();
    rand_inputs();
    round(0, IC);
    rand_inputs();
    round(2, IC);

    repeat (3) step();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
